// File: rtl/hazard_stall_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | hazard_stall_unit: load-use / branch-operand stalls, taken-branch      |
// | flush and data-memory freeze for the 5-stage pipeline.  Rev 1.0        |
// +------------------------------------------------------------------------+
module hazard_stall_unit #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             Branch_Taken,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic [4:0]       EX_MEM_Rd,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    BR_STALL2 = 2'd1,
    MEM_WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] c_wait_max = 8'(WAIT_MAX);

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  state_t           w_eff_state;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic w_ex_hit, w_mem_hit;
  logic w_lu, w_bex, w_bmem, w_mw;
  logic w_freeze, w_stall, w_flush;

  always_comb begin
    w_ex_hit  = (ID_EX_Rd != 5'd0) &&
                ((ID_Rs == ID_EX_Rd) || (ID_UsesRt && (ID_Rt == ID_EX_Rd)));
    w_mem_hit = (EX_MEM_Rd != 5'd0) &&
                ((ID_Rs == EX_MEM_Rd) || (ID_UsesRt && (ID_Rt == EX_MEM_Rd)));
    w_lu      = ID_EX_MemRead && w_ex_hit;
    w_bex     = ID_Branch && ID_EX_RegWrite && w_ex_hit;
    w_bmem    = ID_Branch && EX_MEM_MemRead && w_mem_hit;
    w_mw      = (EX_MEM_MemRead || EX_MEM_MemWrite) && !dmem_ready;
  end

  // While waiting, behave as the state we were in before the freeze began.
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    w_stall       = 1'b0;
    w_flush       = 1'b0;
    w_eff_state   = (state_q == MEM_WAIT) ? ret_q : state_q;
    w_freeze      = (state_q == MEM_WAIT) ? !dmem_ready : w_mw;

    if (w_freeze) begin
      state_d = MEM_WAIT;
      ret_d   = w_eff_state;
      if (wait_cnt_q != 8'hFF) begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
      if (wait_cnt_d >= c_wait_max) begin
        mem_timeout_d = 1'b1;
      end
    end else begin
      wait_cnt_d = 8'd0;
      ret_d      = RUN;
      state_d    = RUN;
      if (w_eff_state == BR_STALL2) begin
        w_stall = 1'b1;
      end else if (w_lu || w_bex || w_bmem) begin
        w_stall = 1'b1;
        // A branch waiting on a load still in EX needs a second bubble.
        if (ID_Branch && w_lu) begin
          state_d = BR_STALL2;
        end
      end else begin
        w_flush = ID_Branch && Branch_Taken;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if ((w_freeze || w_stall) && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Write  = 1'b1;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    MEM_WB_Flush = 1'b0;
    if (!rst_n) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Write  = 1'b0;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else if (w_freeze) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else if (w_stall) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Flush  = 1'b1;
    end else if (w_flush) begin
      IF_ID_Flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      ret_q         <= RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_hazard_stall_unit: vector table, corner sequences and randomized    |
// | comparison against a rule-level model.  Rev 1.0                       |
// +------------------------------------------------------------------------+
module tb_hazard_stall_unit;

  localparam int WAIT_MAX = 2;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       tk;
    logic       ex_mr;
    logic       ex_rw;
    logic [4:0] ex_rd;
    logic       mem_mr;
    logic       mem_mw;
    logic [4:0] mem_rd;
    logic       rdy;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [6:0] o;
    logic       to;
    logic [7:0] cnt;
  } vec_t;

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush}
  localparam logic [6:0] O_NORM  = 7'b1101010;
  localparam logic [6:0] O_STALL = 7'b0001110;
  localparam logic [6:0] O_FLUSH = 7'b1111010;
  localparam logic [6:0] O_FRZ   = 7'b0000001;
  localparam logic [6:0] O_RST   = 7'b0010101;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] ID_Rs, ID_Rt, ID_EX_Rd, EX_MEM_Rd;
  logic ID_UsesRt, ID_Branch, Branch_Taken, ID_EX_MemRead, ID_EX_RegWrite;
  logic EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready;
  logic PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
  logic EX_MEM_Write, MEM_WB_Flush, mem_timeout;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  // rule-level model state
  int m_pend, m_run, m_cnt;
  bit m_wait, m_to;

  vec_t tbl [22];

  hazard_stall_unit #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .Branch_Taken(Branch_Taken),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_Rd(ID_EX_Rd),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_Rd(EX_MEM_Rd),
    .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Write(EX_MEM_Write),
    .MEM_WB_Flush(MEM_WB_Flush), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(input int rs, input int rt, input bit uses, input bit br,
                             input bit tk, input bit exmr, input bit exrw, input int exrd,
                             input bit memmr, input bit memmw, input int memrd, input bit rdy);
    in_t v;
    v.rs = 5'(rs);   v.rt = 5'(rt);   v.uses_rt = uses; v.br = br; v.tk = tk;
    v.ex_mr = exmr;  v.ex_rw = exrw;  v.ex_rd = 5'(exrd);
    v.mem_mr = memmr; v.mem_mw = memmw; v.mem_rd = 5'(memrd); v.rdy = rdy;
    return v;
  endfunction

  task automatic apply(input in_t v);
    ID_Rs = v.rs; ID_Rt = v.rt; ID_UsesRt = v.uses_rt; ID_Branch = v.br;
    Branch_Taken = v.tk; ID_EX_MemRead = v.ex_mr; ID_EX_RegWrite = v.ex_rw;
    ID_EX_Rd = v.ex_rd; EX_MEM_MemRead = v.mem_mr; EX_MEM_MemWrite = v.mem_mw;
    EX_MEM_Rd = v.mem_rd; dmem_ready = v.rdy;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [6:0] eo, input logic eto, input int ecnt);
    chk({nm, " ctl"}, 32'({PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                           ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush}), 32'(eo));
    chk({nm, " timeout"}, 32'(mem_timeout), 32'(eto));
    chk({nm, " count"}, 32'(stall_count), 32'(ecnt));
  endtask

  task automatic run_vec(input string nm, input in_t v, input logic [6:0] eo,
                         input logic eto, input int ecnt);
    @(posedge clk); #1;
    apply(v);
    #4;
    chk_all(nm, eo, eto, ecnt);
  endtask

  // Expected controls follow straight from the hazard rules; the model only
  // remembers an owed branch bubble, whether a freeze is in progress and for how long.
  task automatic model_step(input in_t v, output logic [6:0] eo);
    bit mex, mmem, haz, frozen;
    mex  = (v.ex_rd  != 0) && (v.rs == v.ex_rd  || (v.uses_rt && v.rt == v.ex_rd));
    mmem = (v.mem_rd != 0) && (v.rs == v.mem_rd || (v.uses_rt && v.rt == v.mem_rd));
    haz  = (v.ex_mr && mex) || (v.br && v.ex_rw && mex) || (v.br && v.mem_mr && mmem);
    frozen = m_wait ? !v.rdy : ((v.mem_mr || v.mem_mw) && !v.rdy);
    if (frozen) begin
      eo = O_FRZ;
      m_wait = 1'b1;
      m_run++;
      if (m_run >= WAIT_MAX) m_to = 1'b1;
    end else begin
      m_wait = 1'b0;
      m_run  = 0;
      if (m_pend > 0) begin
        eo = O_STALL;
        m_pend--;
      end else if (haz) begin
        eo = O_STALL;
        if (v.br && v.ex_mr && mex) m_pend = 1;
      end else begin
        eo = (v.br && v.tk) ? O_FLUSH : O_NORM;
      end
    end
    if (!eo[6] && m_cnt < CNT_MAX) m_cnt++;
  endtask

  initial begin
    in_t idle;
    idle = mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    tbl[0]  = '{idle,                                      O_NORM,  1'b0, 8'd0};
    tbl[1]  = '{mk(2, 4, 1, 0, 0, 1, 1, 2, 0, 0, 0, 1),     O_STALL, 1'b0, 8'd0};
    tbl[2]  = '{mk(2, 4, 1, 0, 0, 0, 0, 0, 1, 0, 2, 1),     O_NORM,  1'b0, 8'd1};
    tbl[3]  = '{mk(5, 0, 1, 1, 0, 1, 1, 5, 0, 0, 0, 1),     O_STALL, 1'b0, 8'd1};
    tbl[4]  = '{mk(5, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1),     O_STALL, 1'b0, 8'd2};
    tbl[5]  = '{mk(5, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1),     O_FLUSH, 1'b0, 8'd3};
    tbl[6]  = '{mk(1, 7, 1, 1, 1, 0, 1, 7, 0, 0, 0, 1),     O_STALL, 1'b0, 8'd3};
    tbl[7]  = '{mk(1, 7, 1, 1, 1, 0, 0, 0, 0, 0, 7, 1),     O_FLUSH, 1'b0, 8'd4};
    tbl[8]  = '{mk(0, 3, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1),     O_NORM,  1'b0, 8'd4};
    tbl[9]  = '{mk(1, 6, 0, 0, 0, 1, 1, 6, 0, 0, 0, 1),     O_NORM,  1'b0, 8'd4};
    tbl[10] = '{mk(1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 9, 0),     O_FRZ,   1'b0, 8'd4};
    tbl[11] = '{mk(1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 9, 0),     O_FRZ,   1'b0, 8'd5};
    tbl[12] = '{mk(1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 9, 0),     O_FRZ,   1'b1, 8'd6};
    tbl[13] = '{mk(1, 2, 1, 0, 0, 0, 0, 0, 1, 0, 9, 1),     O_NORM,  1'b1, 8'd7};
    tbl[14] = '{idle,                                      O_NORM,  1'b1, 8'd7};
    tbl[15] = '{mk(5, 0, 1, 1, 0, 1, 1, 5, 0, 0, 0, 1),     O_STALL, 1'b1, 8'd7};
    tbl[16] = '{mk(5, 0, 1, 1, 1, 0, 0, 0, 1, 0, 5, 0),     O_FRZ,   1'b1, 8'd8};
    tbl[17] = '{mk(5, 0, 1, 1, 1, 0, 0, 0, 1, 0, 9, 1),     O_STALL, 1'b1, 8'd9};
    tbl[18] = '{mk(5, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1),     O_FLUSH, 1'b1, 8'd10};
    tbl[19] = '{mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0),     O_FRZ,   1'b1, 8'd10};
    tbl[20] = '{mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1),     O_NORM,  1'b1, 8'd11};
    tbl[21] = '{idle,                                      O_NORM,  1'b1, 8'd11};

    rst_n = 1'b0;
    apply(idle);
    #2;
    chk_all("reset", O_RST, 1'b0, 0);
    #11;
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i].in, tbl[i].o, tbl[i].to, 32'(tbl[i].cnt));
    end

    // reset asserted while the second branch bubble is in progress
    run_vec("brl_stall1", mk(5, 0, 1, 1, 0, 1, 1, 5, 0, 0, 0, 1), O_STALL, 1'b1, 11);
    @(posedge clk); #1;
    apply(mk(5, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1));
    #1;
    chk_all("brl_stall2", O_STALL, 1'b1, 12);
    rst_n = 1'b0;
    #1;
    chk_all("mid_reset", O_RST, 1'b0, 0);
    #2;
    rst_n = 1'b1;
    run_vec("post_reset", mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1), O_NORM, 1'b0, 0);

    // randomized run against the model, starting from a fresh reset
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_pend = 0; m_run = 0; m_cnt = 0; m_wait = 1'b0; m_to = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      in_t        v;
      logic [6:0] eo;
      logic       eto;
      int         ecnt;
      v.rs      = 5'($urandom_range(0, 3));
      v.rt      = 5'($urandom_range(0, 3));
      v.uses_rt = 1'($urandom_range(0, 1));
      v.br      = 1'($urandom_range(0, 1));
      v.tk      = 1'($urandom_range(0, 1));
      v.ex_mr   = 1'($urandom_range(0, 1));
      v.ex_rw   = 1'($urandom_range(0, 1));
      v.ex_rd   = 5'($urandom_range(0, 3));
      v.mem_mr  = 1'($urandom_range(0, 1));
      v.mem_mw  = 1'($urandom_range(0, 3) == 0);
      v.mem_rd  = 5'($urandom_range(0, 3));
      v.rdy     = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      apply(v);
      #4;
      eto  = m_to;
      ecnt = m_cnt;
      model_step(v, eo);
      chk_all($sformatf("rnd%0d", i), eo, eto, ecnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
